dmem_ctrl: RTL

Data-memory access controller in the MEM stage. Turns the current instruction's load/store into an SRAM-like request/handshake, stalls the pipeline until the access completes, and registers the raw read word plus byte offset for the writeback register-source mux. Also generates byte strobes, store-data lane replication and address-alignment exceptions.

---
 rtl/dmem_ctrl_pkg.sv | 35 +++
 rtl/dmem_ctrl_lane_gen.sv | 71 +++++++
 rtl/dmem_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/dmem_ctrl_pkg.sv
// rtl/dmem_ctrl_pkg.sv - shared widths, opcodes, size codes and FSM encodings for dmem_ctrl
package dmem_ctrl_pkg;

  localparam int W_DATA = 32;
  localparam int W_ADDR = 32;
  localparam int W_OPER = 5;

  // MEM-stage operation codes (only the memory ops matter here)
  localparam logic [W_OPER-1:0] OP_NOP = 5'd0;
  localparam logic [W_OPER-1:0] OP_LB  = 5'd1;
  localparam logic [W_OPER-1:0] OP_LBU = 5'd2;
  localparam logic [W_OPER-1:0] OP_LH  = 5'd3;
  localparam logic [W_OPER-1:0] OP_LHU = 5'd4;
  localparam logic [W_OPER-1:0] OP_LW  = 5'd5;
  localparam logic [W_OPER-1:0] OP_SB  = 5'd6;
  localparam logic [W_OPER-1:0] OP_SH  = 5'd7;
  localparam logic [W_OPER-1:0] OP_SW  = 5'd8;
  localparam logic [W_OPER-1:0] OP_ADD = 5'd9;

  // Access size codes driven on the size port
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Access FSM state encodings
  localparam logic [1:0] DMS_IDLE = 2'd0;
  localparam logic [1:0] DMS_WAIT = 2'd1;
  localparam logic [1:0] DMS_DROP = 2'd2;
  localparam logic [1:0] DMS_DONE = 2'd3;

  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] lo);
    return ((sz == SZ_HALF) && lo[0]) || ((sz == SZ_WORD) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/dmem_ctrl_lane_gen.sv
// rtl/dmem_ctrl_lane_gen.sv - combinational size/strobe/lane/alignment decode for one access
// Ports:
//   oper, addr_lo, sdata      : MEM-stage op code, address bits [1:0], store source value
//   is_mem, is_store          : op is a load/store, op is a store
//   size, wstrb, wdata        : access size, byte strobes, lane-replicated store data
//   adel, ades                : misaligned load / misaligned store (not gated by valid)
module dmem_ctrl_lane_gen
  import dmem_ctrl_pkg::*;
(
  input  logic [W_OPER-1:0] oper,
  input  logic [1:0]        addr_lo,
  input  logic [W_DATA-1:0] sdata,
  output logic              is_mem,
  output logic              is_store,
  output logic [1:0]        size,
  output logic [3:0]        wstrb,
  output logic [W_DATA-1:0] wdata,
  output logic              adel,
  output logic              ades
);

  logic mis;

  always_comb begin
    is_mem   = 1'b0;
    is_store = 1'b0;
    size     = SZ_WORD;
    wstrb    = 4'b0000;
    wdata    = sdata;
    case (oper)
      OP_LB, OP_LBU: begin
        is_mem = 1'b1;
        size   = SZ_BYTE;
      end
      OP_LH, OP_LHU: begin
        is_mem = 1'b1;
        size   = SZ_HALF;
      end
      OP_LW: begin
        is_mem = 1'b1;
        size   = SZ_WORD;
      end
      OP_SB: begin
        is_mem   = 1'b1;
        is_store = 1'b1;
        size     = SZ_BYTE;
        wstrb    = 4'b0001 << addr_lo;
        wdata    = {4{sdata[7:0]}};
      end
      OP_SH: begin
        is_mem   = 1'b1;
        is_store = 1'b1;
        size     = SZ_HALF;
        wstrb    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata    = {2{sdata[15:0]}};
      end
      OP_SW: begin
        is_mem   = 1'b1;
        is_store = 1'b1;
        size     = SZ_WORD;
        wstrb    = 4'b1111;
      end
      default: ;
    endcase
  end

  assign mis  = misaligned(size, addr_lo);
  assign adel = is_mem && !is_store && mis;
  assign ades = is_store && mis;

endmodule

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - MEM-stage data-memory request FSM with stall and read-word capture
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   valid, oper, addr, sdata  : live MEM instruction, op code, effective address, store value
//   flush, hold               : MEM instruction killed, MEM instruction not advancing
//   req, wr, size, maddr      : memory request, store flag, access size, request address
//   wstrb, wdata              : byte strobes and lane-replicated store data
//   addr_ok, data_ok, rdata   : request accepted, access complete, read word
//   stall                     : freeze IF..MEM
//   ld_data, word_offset      : captured read word and addr[1:0] for writeback
//   adel, ades                : load / store address error
module dmem_ctrl
  import dmem_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic [W_OPER-1:0] oper,
  input  logic [W_ADDR-1:0] addr,
  input  logic [W_DATA-1:0] sdata,
  input  logic              flush,
  input  logic              hold,
  output logic              req,
  output logic              wr,
  output logic [1:0]        size,
  output logic [W_ADDR-1:0] maddr,
  output logic [3:0]        wstrb,
  output logic [W_DATA-1:0] wdata,
  input  logic              addr_ok,
  input  logic              data_ok,
  input  logic [W_DATA-1:0] rdata,
  output logic              stall,
  output logic [W_DATA-1:0] ld_data,
  output logic [1:0]        word_offset,
  output logic              adel,
  output logic              ades
);

  logic       lg_is_mem;
  logic       lg_is_store;
  logic       lg_adel;
  logic       lg_ades;
  logic       mem_ok;
  logic       capture;
  logic [1:0] state;
  logic [1:0] state_nxt;

  dmem_ctrl_lane_gen u_lane_gen (
    .oper     (oper),
    .addr_lo  (addr[1:0]),
    .sdata    (sdata),
    .is_mem   (lg_is_mem),
    .is_store (lg_is_store),
    .size     (size),
    .wstrb    (wstrb),
    .wdata    (wdata),
    .adel     (lg_adel),
    .ades     (lg_ades)
  );

  assign maddr  = addr;
  assign wr     = lg_is_store;
  assign adel   = valid && lg_adel;
  assign ades   = valid && lg_ades;
  assign mem_ok = valid && lg_is_mem && !lg_adel && !lg_ades;

  // A new request only ever launches from IDLE; DONE blocks re-issue while hold
  // keeps the already-completed instruction sitting in MEM.
  assign req = (state == DMS_IDLE) && mem_ok && !flush;

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    stall     = 1'b0;
    case (state)
      DMS_IDLE: begin
        stall = req;
        if (req && addr_ok) begin
          if (data_ok) begin
            state_nxt = DMS_DONE;
            capture   = 1'b1;
          end else begin
            state_nxt = DMS_WAIT;
          end
        end
      end
      DMS_WAIT: begin
        stall = 1'b1;
        if (data_ok) begin
          state_nxt = DMS_DONE;
          capture   = 1'b1;
        end else if (flush) begin
          state_nxt = DMS_DROP;
        end
      end
      DMS_DROP: begin
        // The bus transaction is already accepted; drain it and drop the data.
        stall = 1'b1;
        if (data_ok) state_nxt = DMS_IDLE;
      end
      DMS_DONE: begin
        if (!hold) state_nxt = DMS_IDLE;
      end
      default: state_nxt = DMS_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= DMS_IDLE;
      ld_data     <= '0;
      word_offset <= 2'b00;
    end else begin
      state <= state_nxt;
      if (capture) begin
        ld_data     <= rdata;
        word_offset <= addr[1:0];
      end
    end
  end

endmodule
